sirv_plic_icb_arb: RTL and testbench
====================================

Name: sirv_plic_icb_arb

Overview:
- Two-requester ICB arbiter and sequencer for the PLIC register port.
- Shares the single PLIC ICB slave between the core (M0) and a secondary configuration agent (M1, e.g. debug or boot-time config engine).
- Round-robin grant, one outstanding transaction, grant locked from command to response.
- Response watchdog: returns an error response if the PLIC never answers, then drains the late reply.

Parameters:
AW, 24, ICB address width (matches PLIC address slice)
DW, 32, ICB data width
TMO_CYC, 64, response timeout in cycles after slave cmd handshake; 0 disables the watchdog
TMO_W, 8, timeout counter width; TMO_CYC must be < 2^TMO_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m0_icb_cmd_valid  in  1  M0 command valid
m0_icb_cmd_ready  out  1  M0 command ready
m0_icb_cmd_addr  in  AW  M0 address
m0_icb_cmd_read  in  1  M0 read(1)/write(0)
m0_icb_cmd_wdata  in  DW  M0 write data
m0_icb_rsp_valid  out  1  M0 response valid
m0_icb_rsp_ready  in  1  M0 response ready
m0_icb_rsp_rdata  out  DW  M0 read data
m0_icb_rsp_err  out  1  M0 response error (timeout)
m1_icb_*  same set and directions as m0_icb_*, for M1
s_icb_cmd_valid  out  1  PLIC command valid
s_icb_cmd_ready  in  1  PLIC command ready
s_icb_cmd_addr  out  AW  PLIC address
s_icb_cmd_read  out  1  PLIC read/write
s_icb_cmd_wdata  out  DW  PLIC write data
s_icb_rsp_valid  in  1  PLIC response valid
s_icb_rsp_ready  out  1  PLIC response ready
s_icb_rsp_rdata  in  DW  PLIC read data
o_busy  out  1  state != IDLE
o_tmo_evt  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Clock and reset: single clock clk; rst asynchronous, active-high.
- Reset values:
  - state=IDLE, gnt=0, last_gnt=1 (M0 wins the first tie), tmo_cnt=0, late_done=0.
  - All valid/ready outputs 0, o_busy=0, o_tmo_evt=0.
  - Reset mid-transaction aborts silently; no response is issued.
- Handshake: ICB valid/ready. A transfer occurs in any cycle with valid & ready high. Masters hold cmd fields stable while valid is high.
- IDLE:
  - Grant sel is combinational: only one valid → that master; both valid → ~last_gnt.
  - s_icb_cmd_* = sel master's fields; sel cmd_ready = s_icb_cmd_ready; other master's cmd_ready=0.
  - Handshake → RSP with gnt=sel latched. Valid without ready → CMD with gnt=sel latched. Zero added command latency.
- CMD:
  - Forward only master gnt. A newly valid other master is ignored.
  - On handshake → RSP.
- RSP:
  - s_icb_rsp_ready = gnt master rsp_ready.
  - gnt rsp_valid = s_icb_rsp_valid, rdata passthrough, err=0. Other master rsp_valid=0.
  - Both cmd_ready=0.
  - Handshake → IDLE; last_gnt<=gnt; tmo_cnt<=0.
  - While no handshake, tmo_cnt increments each cycle when TMO_CYC!=0. When tmo_cnt==TMO_CYC-1 and s_icb_rsp_valid=0 → ERR, pulse o_tmo_evt.
  - An s_icb_rsp_valid held without master ready never times out.
- ERR:
  - gnt rsp_valid=1, rsp_err=1, rdata=0.
  - s_icb_rsp_ready=1; a slave response here is discarded and sets late_done.
  - On master accept: (late_done | s_icb_rsp_valid) → IDLE, otherwise → DRAIN. last_gnt<=gnt in both cases.
- DRAIN: s_icb_rsp_ready=1, no master outputs, no new grants. On s_icb_rsp_valid → IDLE, clear late_done.
- Ordering: no commands are issued before the previous slave response is consumed or drained, so at most one transaction is in flight.
- o_busy=1 in CMD/RSP/ERR/DRAIN.

Test Plan:
- Single M0 read, addr 0x200004, PLIC ready immediately, rsp 2 cycles later rdata=0x5 → m0 rsp rdata=0x5 err=0; m1 outputs stay 0; back in IDLE the following cycle.
- M0 and M1 both valid from reset for 4 transactions each → grants alternate M0,M1,M0,M1…; no cycle has both cmd_ready high.
- M1 write while s_icb_cmd_ready held low 5 cycles; M0 raises valid at cycle 2 → M1 keeps the grant; M0 is served only after M1's response; s_icb_cmd fields stay constant across the wait.
- TMO_CYC=8, PLIC never responds → o_tmo_evt pulses; m0 rsp_valid with err=1, rdata=0; the arbiter enters DRAIN. PLIC responds 20 cycles later → response discarded, IDLE, next M1 request proceeds normally.
- Master rsp_ready held low 100 cycles with s_icb_rsp_valid high, TMO_CYC=8 → no timeout; response delivered intact once ready.
- rst asserted during RSP → all outputs 0 asynchronously; after release the first tie goes to M0.

Source files
------------

// File: rtl/sirv_plic_icb_arb.sv
// Two-requester ICB arbiter/sequencer in front of the PLIC register port.
//   clk, rst          : clock, asynchronous active-high reset
//   m0_icb_* / m1_icb_*: upstream ICB masters (core, config agent)
//   s_icb_*           : downstream ICB slave (PLIC)
//   o_busy            : a transaction is in progress (any state but IDLE)
//   o_tmo_evt         : one-cycle pulse, high in the first cycle of the error response
module sirv_plic_icb_arb #(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int TMO_CYC = 64,
  parameter int TMO_W   = 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [DW-1:0] m0_icb_cmd_wdata,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [DW-1:0] m0_icb_rsp_rdata,
  output logic          m0_icb_rsp_err,

  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [DW-1:0] m1_icb_cmd_wdata,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [DW-1:0] m1_icb_rsp_rdata,
  output logic          m1_icb_rsp_err,

  output logic          s_icb_cmd_valid,
  input  logic          s_icb_cmd_ready,
  output logic [AW-1:0] s_icb_cmd_addr,
  output logic          s_icb_cmd_read,
  output logic [DW-1:0] s_icb_cmd_wdata,
  input  logic          s_icb_rsp_valid,
  output logic          s_icb_rsp_ready,
  input  logic [DW-1:0] s_icb_rsp_rdata,

  output logic          o_busy,
  output logic          o_tmo_evt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RSP,
    ST_ERR,
    ST_DRAIN
  } state_t;

  localparam bit               TMO_EN   = (TMO_CYC != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state;
  logic             gnt;
  logic             last_gnt;
  logic             late_done;
  logic [TMO_W-1:0] tmo_cnt;

  logic             any_vld;
  logic             sel;
  logic             cur;
  logic             cur_vld;
  logic [AW-1:0]    cur_addr;
  logic             cur_read;
  logic [DW-1:0]    cur_wdata;
  logic             cur_rsp_ready;

  assign any_vld = m0_icb_cmd_valid | m1_icb_cmd_valid;
  // Tie goes to the master not served last; a lone requester always wins.
  assign sel     = (m0_icb_cmd_valid & m1_icb_cmd_valid) ? ~last_gnt : m1_icb_cmd_valid;
  // Only IDLE follows the live selection; every other state is locked to gnt.
  assign cur     = (state == ST_IDLE) ? sel : gnt;

  assign cur_vld       = cur ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign cur_addr      = cur ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign cur_read      = cur ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign cur_wdata     = cur ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign cur_rsp_ready = cur ? m1_icb_rsp_ready : m0_icb_rsp_ready;

  // Outputs are forced low while rst is held so reset clears them immediately.
  always_comb begin
    s_icb_cmd_valid  = 1'b0;
    s_icb_cmd_addr   = '0;
    s_icb_cmd_read   = 1'b0;
    s_icb_cmd_wdata  = '0;
    s_icb_rsp_ready  = 1'b0;
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    m0_icb_rsp_valid = 1'b0;
    m1_icb_rsp_valid = 1'b0;
    m0_icb_rsp_rdata = '0;
    m1_icb_rsp_rdata = '0;
    m0_icb_rsp_err   = 1'b0;
    m1_icb_rsp_err   = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_IDLE, ST_CMD: begin
          if (cur_vld) begin
            s_icb_cmd_valid  = 1'b1;
            s_icb_cmd_addr   = cur_addr;
            s_icb_cmd_read   = cur_read;
            s_icb_cmd_wdata  = cur_wdata;
            m0_icb_cmd_ready = s_icb_cmd_ready & ~cur;
            m1_icb_cmd_ready = s_icb_cmd_ready &  cur;
          end
        end
        ST_RSP: begin
          s_icb_rsp_ready  = cur_rsp_ready;
          m0_icb_rsp_valid = s_icb_rsp_valid & ~cur;
          m1_icb_rsp_valid = s_icb_rsp_valid &  cur;
          m0_icb_rsp_rdata = (s_icb_rsp_valid & ~cur) ? s_icb_rsp_rdata : '0;
          m1_icb_rsp_rdata = (s_icb_rsp_valid &  cur) ? s_icb_rsp_rdata : '0;
        end
        ST_ERR: begin
          s_icb_rsp_ready  = 1'b1;
          m0_icb_rsp_valid = ~cur;
          m1_icb_rsp_valid =  cur;
          m0_icb_rsp_err   = ~cur;
          m1_icb_rsp_err   =  cur;
        end
        ST_DRAIN: begin
          s_icb_rsp_ready = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      late_done <= 1'b0;
      tmo_cnt   <= '0;
      o_busy    <= 1'b0;
      o_tmo_evt <= 1'b0;
    end else begin
      o_tmo_evt <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any_vld) begin
            gnt    <= sel;
            o_busy <= 1'b1;
            state  <= s_icb_cmd_ready ? ST_RSP : ST_CMD;
          end
        end
        ST_CMD: begin
          if (cur_vld & s_icb_cmd_ready) begin
            state <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (s_icb_rsp_valid & cur_rsp_ready) begin
            state    <= ST_IDLE;
            o_busy   <= 1'b0;
            last_gnt <= gnt;
            tmo_cnt  <= '0;
          end else if (TMO_EN) begin
            // Counter parks at TMO_LAST: a response held waiting for the
            // master keeps it there without firing.
            if (tmo_cnt == TMO_LAST) begin
              if (!s_icb_rsp_valid) begin
                state     <= ST_ERR;
                tmo_cnt   <= '0;
                o_tmo_evt <= 1'b1;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_ERR: begin
          if (s_icb_rsp_valid) begin
            late_done <= 1'b1;
          end
          if (cur_rsp_ready) begin
            last_gnt <= gnt;
            if (late_done | s_icb_rsp_valid) begin
              state     <= ST_IDLE;
              o_busy    <= 1'b0;
              late_done <= 1'b0;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (s_icb_rsp_valid) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            late_done <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sirv_plic_icb_arb.sv
// Directed bench for sirv_plic_icb_arb with a transaction-level reference model.
module tb_sirv_plic_icb_arb;

  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk;
  logic          rst;
  logic          m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [AW-1:0] m0_icb_cmd_addr;
  logic [DW-1:0] m0_icb_cmd_wdata;
  logic          m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [DW-1:0] m0_icb_rsp_rdata;
  logic          m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [AW-1:0] m1_icb_cmd_addr;
  logic [DW-1:0] m1_icb_cmd_wdata;
  logic          m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [DW-1:0] m1_icb_rsp_rdata;
  logic          s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [AW-1:0] s_icb_cmd_addr;
  logic [DW-1:0] s_icb_cmd_wdata;
  logic          s_icb_rsp_valid, s_icb_rsp_ready;
  logic [DW-1:0] s_icb_rsp_rdata;
  logic          o_busy, o_tmo_evt;

  sirv_plic_icb_arb #(.AW(AW), .DW(DW), .TMO_CYC(TMO), .TMO_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_rsp_valid(m0_icb_rsp_valid),
    .m0_icb_rsp_ready(m0_icb_rsp_ready), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m0_icb_rsp_err(m0_icb_rsp_err),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_rsp_valid(m1_icb_rsp_valid),
    .m1_icb_rsp_ready(m1_icb_rsp_ready), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .m1_icb_rsp_err(m1_icb_rsp_err),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_rsp_valid(s_icb_rsp_valid),
    .s_icb_rsp_ready(s_icb_rsp_ready), .s_icb_rsp_rdata(s_icb_rsp_rdata),
    .o_busy(o_busy), .o_tmo_evt(o_tmo_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the slave, whether the command has
  // been accepted, how long it has waited, and any error/drain obligation.
  int owner     = -1;
  int last      = 1;
  int age       = 0;
  bit cmd_sent  = 0;
  bit failed    = 0;
  bit late_seen = 0;
  bit drain     = 0;
  bit exp_tmo   = 0;

  function automatic logic rr(input int m);
    return (m == 1) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
  endfunction

  function automatic int pick_master();
    if (owner >= 0) return owner;
    if (m0_icb_cmd_valid && m1_icb_cmd_valid) return 1 - last;
    return m1_icb_cmd_valid ? 1 : 0;
  endfunction

  always @(posedge clk) begin : model_update
    int  p;
    bit  ls;
    if (rst) begin
      owner = -1; last = 1; age = 0; cmd_sent = 0;
      failed = 0; late_seen = 0; drain = 0; exp_tmo = 0;
    end else begin
      exp_tmo = 0;
      if (drain) begin
        if (s_icb_rsp_valid) drain = 0;
      end else if (owner < 0 || !cmd_sent) begin
        p = pick_master();
        if ((p == 1) ? m1_icb_cmd_valid : m0_icb_cmd_valid) begin
          owner = p;
          if (s_icb_cmd_ready) begin cmd_sent = 1; age = 0; end
        end
      end else if (!failed) begin
        if (s_icb_rsp_valid && rr(owner)) begin
          last = owner; owner = -1; cmd_sent = 0;
        end else if (!s_icb_rsp_valid && age + 1 >= TMO) begin
          failed = 1; late_seen = 0; exp_tmo = 1;
        end else begin
          age++;
        end
      end else begin
        ls = late_seen;
        if (s_icb_rsp_valid) late_seen = 1;
        if (rr(owner)) begin
          last = owner;
          drain = !(ls || s_icb_rsp_valid);
          owner = -1; failed = 0; cmd_sent = 0; late_seen = 0;
        end
      end
    end
  end

  int          gnt_q[$];
  logic [32:0] m0_q[$];
  logic [32:0] m1_q[$];
  int          tmo_pulses = 0;

  always @(negedge clk) begin : compare
    logic          e_cv, e_r, e_srr, e_busy;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd, e_rd0, e_rd1;
    logic [1:0]    e_crdy, e_rv, e_err;
    int            p;
    e_cv = 0; e_r = 0; e_srr = 0; e_busy = 0;
    e_a = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
    e_crdy = '0; e_rv = '0; e_err = '0;
    if (!rst) begin
      if (drain) begin
        e_srr = 1;
      end else if (owner < 0 || !cmd_sent) begin
        p = pick_master();
        if ((p == 1) ? m1_icb_cmd_valid : m0_icb_cmd_valid) begin
          e_cv = 1;
          e_a  = (p == 1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
          e_r  = (p == 1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
          e_wd = (p == 1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
          e_crdy[p] = s_icb_cmd_ready;
        end
      end else if (!failed) begin
        e_srr = rr(owner);
        e_rv[owner] = s_icb_rsp_valid;
        if (s_icb_rsp_valid) begin
          if (owner == 1) e_rd1 = s_icb_rsp_rdata; else e_rd0 = s_icb_rsp_rdata;
        end
      end else begin
        e_srr = 1;
        e_rv[owner] = 1;
        e_err[owner] = 1;
      end
      e_busy = (owner >= 0) || drain;
    end
    chk("s_cmd_valid", s_icb_cmd_valid, e_cv);
    chk("s_cmd_addr",  s_icb_cmd_addr,  e_a);
    chk("s_cmd_read",  s_icb_cmd_read,  e_r);
    chk("s_cmd_wdata", s_icb_cmd_wdata, e_wd);
    chk("s_rsp_ready", s_icb_rsp_ready, e_srr);
    chk("m0_cmd_ready", m0_icb_cmd_ready, e_crdy[0]);
    chk("m1_cmd_ready", m1_icb_cmd_ready, e_crdy[1]);
    chk("m0_rsp_valid", m0_icb_rsp_valid, e_rv[0]);
    chk("m1_rsp_valid", m1_icb_rsp_valid, e_rv[1]);
    chk("m0_rsp_err",   m0_icb_rsp_err,   e_err[0]);
    chk("m1_rsp_err",   m1_icb_rsp_err,   e_err[1]);
    chk("m0_rsp_rdata", m0_icb_rsp_rdata, e_rd0);
    chk("m1_rsp_rdata", m1_icb_rsp_rdata, e_rd1);
    chk("o_busy",    o_busy,    rst ? 1'b0 : e_busy);
    chk("o_tmo_evt", o_tmo_evt, rst ? 1'b0 : exp_tmo);
    chk("cmd_ready_excl", m0_icb_cmd_ready & m1_icb_cmd_ready, 1'b0);
    if (s_icb_cmd_valid && s_icb_cmd_ready) gnt_q.push_back(m1_icb_cmd_ready ? 1 : 0);
    if (m0_icb_rsp_valid && m0_icb_rsp_ready) m0_q.push_back({m0_icb_rsp_err, m0_icb_rsp_rdata});
    if (m1_icb_rsp_valid && m1_icb_rsp_ready) m1_q.push_back({m1_icb_rsp_err, m1_icb_rsp_rdata});
    if (o_tmo_evt) tmo_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int k;
    int exp_g[8];
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
    rst = 1;
    m0_icb_cmd_valid = 0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 0; m0_icb_cmd_wdata = '0;
    m1_icb_cmd_valid = 0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 0; m1_icb_cmd_wdata = '0;
    m0_icb_rsp_ready = 0; m1_icb_rsp_ready = 0;
    s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_rdata = '0;
    repeat (3) tick();
    chk("reset_busy", o_busy, 1'b0);
    rst = 0;

    // Single M0 read, response two cycles after command.
    m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 24'h200004; m0_icb_cmd_read = 1;
    s_icb_cmd_ready = 1;
    #2 chk("s1_m0_ready", m0_icb_cmd_ready, 1'b1);
    chk("s1_addr", s_icb_cmd_addr, 24'h200004);
    tick();
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    tick();
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h5;
    #2 chk("s1_rdata", m0_icb_rsp_rdata, 32'h5);
    chk("s1_m1_quiet", m1_icb_rsp_valid, 1'b0);
    tick();
    s_icb_rsp_valid = 0; s_icb_rsp_rdata = '0;
    #2 chk("s1_idle", o_busy, 1'b0);
    chk("s1_rsp_count", m0_q.size(), 1);
    if (m0_q.size() > 0) chk("s1_rsp", m0_q[0], {1'b0, 32'h5});

    // Both masters competing from reset: strict alternation starting with M0.
    rst = 1; tick(); rst = 0;
    gnt_q.delete(); m1_q.delete();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 24'h10; m0_icb_cmd_read = 1;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 24'h20; m1_icb_cmd_read = 0;
    m1_icb_cmd_wdata = 32'h1111;
    for (int i = 0; i < 8; i++) begin
      s_icb_cmd_ready = 1;
      tick();
      if (i == 6) m0_icb_cmd_valid = 0;
      if (i == 7) m1_icb_cmd_valid = 0;
      s_icb_cmd_ready = 0; s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h100 + 32'(i);
      tick();
      s_icb_rsp_valid = 0;
    end
    chk("s2_gnt_count", gnt_q.size(), 8);
    for (int i = 0; i < 8 && i < gnt_q.size(); i++) chk("s2_gnt_order", gnt_q[i], exp_g[i]);
    if (m1_q.size() == 4) chk("s2_m1_last", m1_q[3], {1'b0, 32'h107});
    else chk("s2_m1_count", m1_q.size(), 4);

    // M1 write stalled by slave; M0 arrives mid-stall and must wait.
    gnt_q.delete();
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 24'h000ABC; m1_icb_cmd_read = 0;
    m1_icb_cmd_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 24'h40; m0_icb_cmd_read = 1;
      end
      #2 chk("s3_hold_addr", s_icb_cmd_addr, 24'h000ABC);
      chk("s3_hold_wdata", s_icb_cmd_wdata, 32'hDEADBEEF);
      chk("s3_m0_blocked", m0_icb_cmd_ready, 1'b0);
      tick();
    end
    s_icb_cmd_ready = 1;
    tick();
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h55;
    #2 chk("s3_m0_wait_rsp", m0_icb_cmd_ready, 1'b0);
    tick();
    s_icb_rsp_valid = 0; s_icb_cmd_ready = 1;
    tick();
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h66;
    tick();
    s_icb_rsp_valid = 0;
    chk("s3_gnt_count", gnt_q.size(), 2);
    if (gnt_q.size() == 2) begin
      chk("s3_gnt0", gnt_q[0], 1);
      chk("s3_gnt1", gnt_q[1], 0);
    end

    // Slave never answers: timeout, error response, drain of late reply.
    tmo_pulses = 0; m0_q.delete(); m1_q.delete();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 24'h123; m0_icb_cmd_read = 1;
    s_icb_cmd_ready = 1;
    tick();
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    k = 0;
    do begin
      tick(); #2; k++;
    end while (!m0_icb_rsp_valid && k < 50);
    chk("s4_tmo_latency", k, TMO);
    chk("s4_tmo_evt", o_tmo_evt, 1'b1);
    chk("s4_err", m0_icb_rsp_err, 1'b1);
    chk("s4_err_rdata", m0_icb_rsp_rdata, 32'h0);
    tick();
    #2 chk("s4_drain_busy", o_busy, 1'b1);
    chk("s4_drain_quiet", m0_icb_rsp_valid, 1'b0);
    repeat (20) tick();
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h77;
    #2 chk("s4_late_dropped", m0_icb_rsp_valid, 1'b0);
    chk("s4_late_ready", s_icb_rsp_ready, 1'b1);
    tick();
    s_icb_rsp_valid = 0;
    #2 chk("s4_idle", o_busy, 1'b0);
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 24'h300; m1_icb_cmd_read = 1;
    s_icb_cmd_ready = 1;
    tick();
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h99;
    tick();
    s_icb_rsp_valid = 0;
    chk("s4_m0_err_count", m0_q.size(), 1);
    if (m0_q.size() > 0) chk("s4_m0_err_rsp", m0_q[0], {1'b1, 32'h0});
    chk("s4_m1_count", m1_q.size(), 1);
    if (m1_q.size() > 0) chk("s4_m1_rsp", m1_q[0], {1'b0, 32'h99});

    // Late reply arrives while the error response is still pending.
    m0_icb_rsp_ready = 0;
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 24'h124; m0_icb_cmd_read = 1;
    s_icb_cmd_ready = 1;
    tick();
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    repeat (TMO) tick();
    #2 chk("s4b_err", m0_icb_rsp_err, 1'b1);
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h88;
    tick();
    s_icb_rsp_valid = 0; m0_icb_rsp_ready = 1;
    tick();
    #2 chk("s4b_idle", o_busy, 1'b0);

    // Response held by a slow master never times out.
    m0_icb_rsp_ready = 0; m0_q.delete();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 24'h44; m0_icb_cmd_read = 1;
    s_icb_cmd_ready = 1;
    tick();
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hCAFE;
    repeat (100) tick();
    #2 chk("s5_still_valid", m0_icb_rsp_valid, 1'b1);
    chk("s5_no_err", m0_icb_rsp_err, 1'b0);
    m0_icb_rsp_ready = 1;
    tick();
    s_icb_rsp_valid = 0;
    chk("s5_rsp_count", m0_q.size(), 1);
    if (m0_q.size() > 0) chk("s5_rsp", m0_q[0], {1'b0, 32'hCAFE});
    chk("tmo_pulses", tmo_pulses, 2);

    // Asynchronous reset mid-response; the first tie after release goes to M0.
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 24'h55; m0_icb_cmd_read = 1;
    s_icb_cmd_ready = 1;
    tick();
    m0_icb_cmd_addr = 24'h77;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 24'h66; m1_icb_cmd_read = 1;
    s_icb_cmd_ready = 0; s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hAA;
    #2 rst = 1;
    #1 chk("s6_rst_m0_rsp", m0_icb_rsp_valid, 1'b0);
    chk("s6_rst_s_cmd", s_icb_cmd_valid, 1'b0);
    chk("s6_rst_rsp_ready", s_icb_rsp_ready, 1'b0);
    chk("s6_rst_addr", s_icb_cmd_addr, 24'h0);
    chk("s6_rst_busy", o_busy, 1'b0);
    tick(); tick();
    rst = 0; s_icb_rsp_valid = 0; s_icb_cmd_ready = 1;
    #2 chk("s6_tie_m0", m0_icb_cmd_ready, 1'b1);
    chk("s6_tie_m1", m1_icb_cmd_ready, 1'b0);
    chk("s6_tie_addr", s_icb_cmd_addr, 24'h77);
    tick();
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hBB;
    tick();
    s_icb_rsp_valid = 0; s_icb_cmd_ready = 1;
    tick();
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hCC;
    tick();
    s_icb_rsp_valid = 0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
